// File: rtl/mem_access_pkg.sv
// mem_access_pkg
// Shared definitions for the memory-access stage: FSM state encoding,
// access-size codes, byte-enable constants and small address/extension
// helpers used by both the top level and the lane-alignment sub-module.
package mem_access_pkg;

    // Access-size codes as presented on i_size.
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_ILL  = 2'b11;

    // Byte-enable patterns (bit 3 = most significant lane = offset 0).
    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_BYTE0   = 4'b1000;

    // Access sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Word-aligned bus address for any byte address.
    function automatic logic [31:0] word_addr(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    // Sign- or zero-extend a byte to 32 bits.
    function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic sgn);
        return {{24{sgn & b[7]}}, b};
    endfunction

    // Sign- or zero-extend a halfword to 32 bits.
    function automatic logic [31:0] ext_half(input logic [15:0] h, input logic sgn);
        return {{16{sgn & h[15]}}, h};
    endfunction

endpackage

// File: rtl/mem_access_load_store_align.sv
// mem_access_load_store_align
// Purely combinational lane steering for a big-endian 32-bit data bus.
// Ports:
//   offset     in  2   byte offset addr[1:0]
//   size       in  2   access size code
//   sign_ext   in  1   sign-extend sub-word loads
//   op2        in  32  raw store data
//   rdata      in  32  word read from memory
//   be         out 4   byte enables (0 when misaligned)
//   wdata      out 32  lane-replicated store data
//   load_data  out 32  extracted and extended load data
//   misaligned out 1   access cannot be issued
module mem_access_load_store_align
    import mem_access_pkg::*;
(
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] op2,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misaligned
);

    logic [7:0]  byte_lane_s;
    logic [15:0] half_lane_s;

    // Select the byte lane addressed by the offset (offset 0 is the MSB lane).
    always_comb begin
        byte_lane_s = 8'h00;
        case (offset)
            2'd0:    byte_lane_s = rdata[31:24];
            2'd1:    byte_lane_s = rdata[23:16];
            2'd2:    byte_lane_s = rdata[15:8];
            2'd3:    byte_lane_s = rdata[7:0];
            default: byte_lane_s = 8'h00;
        endcase
    end

    // Select the halfword lane; only offsets 0 and 2 are legal, offset[1] picks it.
    always_comb begin
        half_lane_s = 16'h0000;
        if (offset[1]) begin
            half_lane_s = rdata[15:0];
        end else begin
            half_lane_s = rdata[31:16];
        end
    end

    // Byte enables, store replication, load extension and alignment check.
    always_comb begin
        be         = BE_NONE;
        wdata      = 32'h0000_0000;
        load_data  = 32'h0000_0000;
        misaligned = 1'b0;
        case (size)
            SIZE_BYTE: begin
                be        = BE_BYTE0 >> offset;
                wdata     = {4{op2[7:0]}};
                load_data = ext_byte(byte_lane_s, sign_ext);
            end
            SIZE_HALF: begin
                if (offset[0]) begin
                    misaligned = 1'b1;
                end else begin
                    be        = offset[1] ? BE_HALF_LO : BE_HALF_HI;
                    wdata     = {2{op2[15:0]}};
                    load_data = ext_half(half_lane_s, sign_ext);
                end
            end
            SIZE_WORD: begin
                if (offset != 2'b00) begin
                    misaligned = 1'b1;
                end else begin
                    be        = BE_WORD;
                    wdata     = op2;
                    load_data = rdata;
                end
            end
            default: begin
                misaligned = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// mem_access
// Memory-access stage of the unpipelined MIPS core. Issues one load or
// store per instruction over a req/ack port, stalls the core until the
// access completes or times out, and returns extended load data.
// Ports:
//   i_clk, i_rst                   clock, synchronous active-high reset
//   i_valid, i_ALUres, i_op2       instruction, effective address, store data
//   i_memRead, i_memWrite          load / store (store wins)
//   i_size, i_signed               access size, sign-extend loads
//   o_mem_req/we/addr/be/wdata     registered bus request
//   i_mem_ack, i_mem_rdata         bus completion and read word
//   o_stall                        combinational freeze of PC/upstream
//   o_done                         one-cycle completion pulse
//   o_rdata                        registered extracted load data
//   o_wbData                       write-back value
//   o_misaligned, o_timeout        one-cycle error pulses
module mem_access
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic [31:0] i_ALUres,
    input  logic [31:0] i_op2,
    input  logic        i_memRead,
    input  logic        i_memWrite,
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [3:0]  o_mem_be,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata,
    output logic        o_stall,
    output logic        o_done,
    output logic [31:0] o_rdata,
    output logic [31:0] o_wbData,
    output logic        o_misaligned,
    output logic        o_timeout
);

    localparam int              CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t            state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              req_r;
    logic              we_r;
    logic [31:0]       addr_r;
    logic [3:0]        be_r;
    logic [31:0]       wdata_r;
    logic              done_r;
    logic [31:0]       rdata_r;
    logic              misaligned_r;
    logic              timeout_r;

    logic              memop_s;
    logic              stall_s;
    logic [3:0]        be_s;
    logic [31:0]       wdata_s;
    logic [31:0]       load_data_s;
    logic              misaligned_s;

    assign memop_s = i_memRead | i_memWrite;

    mem_access_load_store_align u_align (
        .offset     (i_ALUres[1:0]),
        .size       (i_size),
        .sign_ext   (i_signed),
        .op2        (i_op2),
        .rdata      (i_mem_rdata),
        .be         (be_s),
        .wdata      (wdata_s),
        .load_data  (load_data_s),
        .misaligned (misaligned_s)
    );

    // Stall while a memory op waits to be issued or is in flight.
    always_comb begin
        stall_s = (state_r == ST_BUSY) |
                  ((state_r == ST_IDLE) & i_valid & memop_s);
    end

    // Access sequencer with its timeout counter and all registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r      <= ST_IDLE;
            cnt_r        <= '0;
            req_r        <= 1'b0;
            we_r         <= 1'b0;
            addr_r       <= 32'h0000_0000;
            be_r         <= 4'b0000;
            wdata_r      <= 32'h0000_0000;
            done_r       <= 1'b0;
            rdata_r      <= 32'h0000_0000;
            misaligned_r <= 1'b0;
            timeout_r    <= 1'b0;
        end else begin
            // Status outputs are single-cycle pulses unless set below.
            done_r       <= 1'b0;
            misaligned_r <= 1'b0;
            timeout_r    <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (i_valid && memop_s) begin
                        if (misaligned_s) begin
                            // Rejected without touching the bus.
                            misaligned_r <= 1'b1;
                            done_r       <= 1'b1;
                            rdata_r      <= 32'h0000_0000;
                            state_r      <= ST_DONE;
                        end else begin
                            req_r   <= 1'b1;
                            we_r    <= i_memWrite;
                            addr_r  <= word_addr(i_ALUres);
                            be_r    <= be_s;
                            wdata_r <= wdata_s;
                            cnt_r   <= '0;
                            state_r <= ST_BUSY;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    // An ack in the final allowed cycle still completes normally.
                    if (i_mem_ack) begin
                        rdata_r <= we_r ? 32'h0000_0000 : load_data_s;
                        req_r   <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
                    end else if (cnt_r == CNT_LAST) begin
                        rdata_r   <= 32'h0000_0000;
                        req_r     <= 1'b0;
                        timeout_r <= 1'b1;
                        done_r    <= 1'b1;
                        state_r   <= ST_DONE;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    req_r   <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_mem_req    = req_r;
    assign o_mem_we     = we_r;
    assign o_mem_addr   = addr_r;
    assign o_mem_be     = be_r;
    assign o_mem_wdata  = wdata_r;
    assign o_stall      = stall_s;
    assign o_done       = done_r;
    assign o_rdata      = rdata_r;
    assign o_wbData     = i_memRead ? rdata_r : i_ALUres;
    assign o_misaligned = misaligned_r;
    assign o_timeout    = timeout_r;

endmodule
